// File: rtl/board_reset_seq.sv
// ============================================================================
//  Module      : board_reset_seq
//  Description : Board-level reset and USB-attach sequencer. Synchronises the
//                PLL lock and the board buttons, debounces the buttons, holds
//                the bootloader core in reset and forces the USB pads to SE0
//                for a programmable detach time so the host re-enumerates.
//  Optional    : `define BOOT_LONGPRESS_EN to enable a long-press boot
//                request on the reset button (boot_req pulse).
//  Ports       : clk_48mhz  - sole clock
//                reset_n    - asynchronous active-low reset
//                pll_lock   - asynchronous PLL lock input
//                btn        - raw asynchronous buttons, active high
//                btn_db     - debounced buttons
//                core_reset - active-high reset to the bootloader core
//                usb_detach - high: top drives D+/D- low (SE0)
//                boot_req   - one-cycle boot request pulse
//                seq_state  - current sequencer state code (LED/debug)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_reset_seq #(
    parameter int NUM_BTN          = 7,
    parameter int RESET_BTN        = 1,
    parameter int DEBOUNCE_CYCLES  = 65536,
    parameter int DETACH_CYCLES    = 480000,
    parameter int LONGPRESS_CYCLES = 96000000
) (
    input  logic               clk_48mhz,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_db,
    output logic               core_reset,
    output logic               usb_detach,
    output logic               boot_req,
    output logic [1:0]         seq_state
);

    // The sequencer counter is shared between the detach down-count and the
    // optional long-press up-count, so it is sized for the larger of the two.
    localparam int CNT_MAX = (DETACH_CYCLES > LONGPRESS_CYCLES) ? DETACH_CYCLES : LONGPRESS_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] C_DETACH_LOAD = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [DB_W-1:0]  C_DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef BOOT_LONGPRESS_EN
    localparam logic [CNT_W-1:0] C_LP_LAST     = CNT_W'(LONGPRESS_CYCLES - 1);
    localparam logic             C_LP_ONE      = (LONGPRESS_CYCLES == 1);
`endif

    localparam logic [1:0] S_LOCK   = 2'd0;
    localparam logic [1:0] S_DETACH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous inputs
    // ------------------------------------------------------------------
    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_btn_meta  <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;
            r_btn_meta  <= btn;
            r_btn_sync  <= r_btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debouncer: the output only follows the input once it has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
            logic [DB_W-1:0] r_db_cnt;
            logic            r_db;

            always_ff @(posedge clk_48mhz or negedge reset_n) begin
                if (!reset_n) begin
                    r_db_cnt <= '0;
                    r_db     <= 1'b0;
                end else if (r_btn_sync[gi] == r_db) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == C_DB_LAST) begin
                    r_db_cnt <= '0;
                    r_db     <= ~r_db;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            assign btn_db[gi] = r_db;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic             r_rst_btn_prev;
    logic             w_rst_rise;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_rst_rise = btn_db[RESET_BTN] & ~r_rst_btn_prev;

`ifdef BOOT_LONGPRESS_EN
    logic w_boot_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
`ifdef BOOT_LONGPRESS_EN
        w_boot_nxt  = 1'b0;
`endif
        // Losing lock overrides every other transition, including a button
        // press on the same edge.
        if (!r_lock_sync) begin
            w_state_nxt = S_LOCK;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_LOCK: begin
                    w_state_nxt = S_DETACH;
                    w_cnt_nxt   = C_DETACH_LOAD;
                end
                S_DETACH: begin
                    if (w_rst_rise) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
`ifdef BOOT_LONGPRESS_EN
                        w_boot_nxt  = C_LP_ONE;
`endif
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_rst_rise) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
`ifdef BOOT_LONGPRESS_EN
                        w_boot_nxt  = C_LP_ONE;
`endif
                    end
                end
                default: begin // S_HOLD
                    if (!btn_db[RESET_BTN]) begin
                        w_state_nxt = S_DETACH;
                        w_cnt_nxt   = C_DETACH_LOAD;
`ifdef BOOT_LONGPRESS_EN
                    end else if (r_cnt != C_LP_LAST) begin
                        // Count saturates at the last value so a long hold
                        // produces exactly one pulse.
                        w_cnt_nxt  = r_cnt + 1'b1;
                        w_boot_nxt = ((r_cnt + 1'b1) == C_LP_LAST);
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_LOCK;
            r_cnt          <= '0;
            r_rst_btn_prev <= 1'b0;
            core_reset     <= 1'b1;
            usb_detach     <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rst_btn_prev <= btn_db[RESET_BTN];
            core_reset     <= (w_state_nxt != S_RUN);
            usb_detach     <= (w_state_nxt != S_RUN);
        end
    end

`ifdef BOOT_LONGPRESS_EN
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            boot_req <= 1'b0;
        end else begin
            boot_req <= w_boot_nxt;
        end
    end
`else
    assign boot_req = 1'b0;
`endif

    assign seq_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_board_reset_seq.sv
// ============================================================================
//  Module      : tb_board_reset_seq
//  Description : Self-checking bench for board_reset_seq: directed latency
//                and boundary checks plus randomized lock/button/reset
//                activity compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_reset_seq;

    localparam int NUM_BTN   = 2;
    localparam int RESET_BTN = 1;
    localparam int DEB       = 4;
    localparam int DET       = 8;
    localparam int LP        = 20;

    logic               clk_48mhz = 1'b0;
    logic               reset_n;
    logic               pll_lock;
    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] btn_db;
    logic               core_reset;
    logic               usb_detach;
    logic               boot_req;
    logic [1:0]         seq_state;

    int checks = 0;
    int errors = 0;

    board_reset_seq #(
        .NUM_BTN          (NUM_BTN),
        .RESET_BTN        (RESET_BTN),
        .DEBOUNCE_CYCLES  (DEB),
        .DETACH_CYCLES    (DET),
        .LONGPRESS_CYCLES (LP)
    ) dut (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .btn        (btn),
        .btn_db     (btn_db),
        .core_reset (core_reset),
        .usb_detach (usb_detach),
        .boot_req   (boot_req),
        .seq_state  (seq_state)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Modes use the published state codes
    // (0 lock, 1 detach, 2 run, 3 hold); detach is tracked as the edge
    // number at which it ends, hold as the edge number it began.
    // ------------------------------------------------------------------
    int               m_cyc;
    int               m_mode;
    int               m_det_end;
    int               m_hold_start;
    bit               m_boot;
    bit               m_lock_h0, m_lock_h1;
    bit [NUM_BTN-1:0] m_btn_h0, m_btn_h1;
    bit [NUM_BTN-1:0] m_db;
    int               m_run [NUM_BTN];
    bit               m_prev;

    task automatic model_step();
        bit lk;
        bit rise;
        int nmode;
        if (!reset_n) begin
            m_cyc = 0; m_mode = 0; m_det_end = 0; m_hold_start = 0; m_boot = 0;
            m_lock_h0 = 0; m_lock_h1 = 0; m_btn_h0 = '0; m_btn_h1 = '0;
            m_db = '0; m_prev = 0;
            for (int b = 0; b < NUM_BTN; b++) m_run[b] = 0;
            return;
        end
        m_cyc++;
        lk    = m_lock_h1;
        rise  = m_db[RESET_BTN] && !m_prev;
        nmode = m_mode;
        m_boot = 0;
        if (!lk) begin
            nmode = 0;
        end else begin
            case (m_mode)
                0: begin nmode = 1; m_det_end = m_cyc + DET; end
                1: begin
                    if (rise) begin nmode = 3; m_hold_start = m_cyc; end
                    else if (m_cyc == m_det_end) nmode = 2;
                end
                2: if (rise) begin nmode = 3; m_hold_start = m_cyc; end
                default: begin
                    if (!m_db[RESET_BTN]) begin
                        nmode = 1; m_det_end = m_cyc + DET;
                    end else begin
`ifdef BOOT_LONGPRESS_EN
                        if (m_cyc - m_hold_start == LP - 1) m_boot = 1;
`endif
                    end
                end
            endcase
        end
        m_prev = m_db[RESET_BTN];
        for (int b = 0; b < NUM_BTN; b++) begin
            if (m_btn_h1[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_db[b]  = ~m_db[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_lock_h1 = m_lock_h0; m_lock_h0 = pll_lock;
        m_btn_h1  = m_btn_h0;  m_btn_h0  = btn;
        m_mode = nmode;
    endtask

    initial begin
        forever begin
            @(posedge clk_48mhz or negedge reset_n);
            model_step();
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_48mhz);
            if (reset_n) begin
                check_eq("seq_state",  32'(seq_state),  32'(m_mode));
                check_eq("core_reset", 32'(core_reset), 32'(m_mode != 2));
                check_eq("usb_detach", 32'(usb_detach), 32'(m_mode != 2));
                check_eq("boot_req",   32'(boot_req),   32'(m_boot));
                check_eq("btn_db",     32'(btn_db),     32'(m_db));
            end
        end
    end

    // Wait (bounded) until the model reaches a mode; for detach also a
    // specific remaining count (cycles left minus one).
    task automatic wait_model(input int mode, input int left, input int budget, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_48mhz);
            if (m_mode == mode && (mode != 1 || (m_det_end - m_cyc - 1) == left)) found = 1;
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    int hold [NUM_BTN];

    initial begin
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        btn      = '0;
        repeat (3) @(posedge clk_48mhz);
        #1;
        check_eq("rst_core_reset", 32'(core_reset), 32'd1);
        check_eq("rst_usb_detach", 32'(usb_detach), 32'd1);
        check_eq("rst_boot_req",   32'(boot_req),   32'd0);
        check_eq("rst_btn_db",     32'(btn_db),     32'd0);
        check_eq("rst_seq_state",  32'(seq_state),  32'd0);

        // Lock-up latency: edges counted from reset release.
        @(negedge clk_48mhz); reset_n = 1'b1;
        repeat (9) @(posedge clk_48mhz);
        @(negedge clk_48mhz); pll_lock = 1'b1;            // before edge 10
        repeat (2) @(posedge clk_48mhz); #1;
        check_eq("lock_seq_e11", 32'(seq_state), 32'd0);
        @(posedge clk_48mhz); #1;
        check_eq("lock_seq_e12", 32'(seq_state), 32'd1);
        repeat (7) @(posedge clk_48mhz); #1;
        check_eq("lock_core_reset_e19", 32'(core_reset), 32'd1);
        @(posedge clk_48mhz); #1;
        check_eq("lock_core_reset_e20", 32'(core_reset), 32'd0);
        check_eq("lock_usb_detach_e20", 32'(usb_detach), 32'd0);
        check_eq("lock_seq_e20",        32'(seq_state),  32'd2);

        // Debounce: short glitch, then a held press.
        @(negedge clk_48mhz); btn[0] = 1'b1;
        repeat (3) @(negedge clk_48mhz); btn[0] = 1'b0;
        repeat (8) @(posedge clk_48mhz); #1;
        check_eq("db_glitch", 32'(btn_db[0]), 32'd0);
        @(negedge clk_48mhz); btn[0] = 1'b1;
        repeat (5) @(posedge clk_48mhz); #1;
        check_eq("db_e5", 32'(btn_db[0]), 32'd0);
        @(posedge clk_48mhz); #1;
        check_eq("db_e6", 32'(btn_db[0]), 32'd1);

        // Button reset: 30-cycle press, then lock loss mid-detach.
        @(negedge clk_48mhz); btn[1] = 1'b1;
        repeat (30) @(negedge clk_48mhz); btn[1] = 1'b0;
        wait_model(1, 3, 60, "btnrst_detach_cnt3");
        pll_lock = 1'b0;
        repeat (4) @(negedge clk_48mhz); pll_lock = 1'b1;
        wait_model(2, 0, 60, "relock_run");

        // Lock loss while running.
        pll_lock = 1'b0;
        repeat (3) @(negedge clk_48mhz); pll_lock = 1'b1;
        wait_model(2, 0, 60, "relock_run2");

        // Asynchronous reset between edges while running.
        @(negedge clk_48mhz);
        #2 reset_n = 1'b0;
        #1;
        check_eq("areset_core_reset", 32'(core_reset), 32'd1);
        check_eq("areset_usb_detach", 32'(usb_detach), 32'd1);
        check_eq("areset_btn_db",     32'(btn_db),     32'd0);
        check_eq("areset_seq_state",  32'(seq_state),  32'd0);
        #1 reset_n = 1'b1;

        // Randomized activity.
        for (int b = 0; b < NUM_BTN; b++) hold[b] = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_48mhz);
            if (pll_lock) begin
                if ($urandom_range(0, 299) == 0) pll_lock = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                pll_lock = 1'b1;
            end
            for (int b = 0; b < NUM_BTN; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = ~btn[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 45));
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 1999) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
